// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ready handshake and drives the IF/ID register.
// Redirects that arrive during an outstanding fetch are parked until the response retires, then applied.
//
// state   | meaning
// S_FETCH | request outstanding at pc; response either delivered, parked in hbuf, or killed
// S_HOLD  | response arrived under stall; word parked in hbuf, no request issued
module if_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] IF_pc_out,
   output logic [31:0] IF_instr_out,
   output logic        IF_valid
);

   localparam logic [0:0] S_FETCH = 1'b0;
   localparam logic [0:0] S_HOLD  = 1'b1;

   logic [0:0]  state, state_nxt;
   logic [31:0] pc, pc_nxt;
   logic        pend, pend_nxt;
   logic [31:0] pend_pc, pend_pc_nxt;
   logic [31:0] hbuf, hbuf_nxt;
   logic        deliver;
   logic [31:0] deliver_instr;
   logic [31:0] redir_tgt;
   logic [31:0] pc_inc;
   logic        kill;

   assign redir_tgt = {redirect_pc[31:2], 2'b00};
   assign pc_inc    = pc + 32'd4;
   assign kill      = pend | redirect_valid;

   assign imem_req  = (state == S_FETCH) && !rst;
   assign imem_addr = pc;

   always_comb begin
      state_nxt     = state;
      pc_nxt        = pc;
      pend_nxt      = pend;
      pend_pc_nxt   = pend_pc;
      hbuf_nxt      = hbuf;
      deliver       = 1'b0;
      deliver_instr = hbuf;
      case (state)
         S_FETCH: begin
            if (!imem_ready) begin
               // the address must stay put until the memory answers, so park the target
               if (redirect_valid) begin
                  pend_nxt    = 1'b1;
                  pend_pc_nxt = redir_tgt;
               end
            end else if (kill) begin
               pc_nxt   = redirect_valid ? redir_tgt : pend_pc;
               pend_nxt = 1'b0;
            end else if (stall) begin
               hbuf_nxt  = imem_rdata;
               state_nxt = S_HOLD;
            end else begin
               deliver       = 1'b1;
               deliver_instr = imem_rdata;
               pc_nxt        = pc_inc;
            end
         end
         S_HOLD: begin
            if (redirect_valid) begin
               pc_nxt    = redir_tgt;
               state_nxt = S_FETCH;
            end else if (!stall) begin
               deliver   = 1'b1;
               pc_nxt    = pc_inc;
               state_nxt = S_FETCH;
            end
         end
         default: state_nxt = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_FETCH;
         pc      <= {RESET_PC[31:2], 2'b00};
         pend    <= 1'b0;
         pend_pc <= 32'd0;
         hbuf    <= NOP_INSTR;
      end else begin
         state   <= state_nxt;
         pc      <= pc_nxt;
         pend    <= pend_nxt;
         pend_pc <= pend_pc_nxt;
         hbuf    <= hbuf_nxt;
      end
   end

   // IF/ID: flush beats stall beats delivery; anything else is a bubble that keeps the old pc
   always_ff @(posedge clk) begin
      if (rst) begin
         IF_pc_out    <= 32'd0;
         IF_instr_out <= NOP_INSTR;
         IF_valid     <= 1'b0;
      end else if (flush) begin
         IF_instr_out <= NOP_INSTR;
         IF_valid     <= 1'b0;
      end else if (stall) begin
         IF_valid     <= IF_valid;
      end else if (deliver) begin
         IF_pc_out    <= pc;
         IF_instr_out <= deliver_instr;
         IF_valid     <= 1'b1;
      end else begin
         IF_instr_out <= NOP_INSTR;
         IF_valid     <= 1'b0;
      end
   end

endmodule
